// File: rtl/fft_stage_sequencer_if.sv
// Generator-side bundle of the FFT stage sequencer:
// stage control out, generator completion back.
interface fft_stage_sequencer_if;
    logic       should_run;
    logic       stage_start;
    logic [4:0] stage_count;
    logic       bank_sel;
    logic       gen_done;

    modport master (
        output should_run,
        output stage_start,
        output stage_count,
        output bank_sel,
        input  gen_done
    );

    modport slave (
        input  should_run,
        input  stage_start,
        input  stage_count,
        input  bank_sel,
        output gen_done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage-level controller for the in-place radix-2 FFT engine.
// Runs each butterfly stage, drains the pipe, flips the ping-pong bank.
module fft_stage_sequencer #(
    parameter int unsigned FFT_N        = 10,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         fft_done,
    output logic                         last_bank,
    fft_stage_sequencer_if.master        gen
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [4:0] LAST_STAGE = 5'(FFT_N - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] stage_q, stage_d;
    logic       bank_q, bank_d;
    logic       last_q, last_d;
    logic       sstart_q, sstart_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort overrides everything, DRAIN ignores gen_done
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:   if (start) state_d = RUN;
                RUN:    if (gen.gen_done) state_d = DRAIN;
                DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_d = (stage_q == LAST_STAGE) ? FINISH : RUN;
                    end
                end
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage index, bank, drain counter and result bank updates
    always_comb begin
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        bank_d   = bank_q;
        last_d   = last_q;
        sstart_d = (state_d == RUN) && (state_q != RUN);
        if (!abort) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        stage_d = 5'd0;
                        bank_d  = 1'b0;
                    end
                end
                RUN: begin
                    if (gen.gen_done) cnt_d = DRAIN_LOAD;
                end
                DRAIN: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (stage_q != LAST_STAGE) begin
                        stage_d = stage_q + 5'd1;
                        bank_d  = ~bank_q;
                    end
                end
                FINISH: last_d = ~bank_q;
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            stage_q  <= 5'd0;
            bank_q   <= 1'b0;
            last_q   <= 1'b0;
            sstart_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            bank_q   <= bank_d;
            last_q   <= last_d;
            sstart_q <= sstart_d;
        end
    end

    // Outputs decoded from state and datapath registers
    always_comb begin
        busy            = (state_q != IDLE);
        fft_done        = (state_q == FINISH);
        gen.should_run  = (state_q == RUN);
        gen.stage_start = sstart_q;
        gen.stage_count = stage_q;
        gen.bank_sel    = bank_q;
        last_bank       = last_q;
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Stage-level controller for the in-place radix-2 FFT engine. On a `start` request it steps the FFT address generator through all `FFT_N` butterfly stages. For each stage it sets the stage index, holds the run enable until the generator reports completion, then drains the butterfly pipeline and flips the ping-pong memory bank. It sits between the top-level audio/fingerprint control logic and the address generator / butterfly datapath, and it reports busy/done to the requester.

## Interface
- `FFT_N`, default 10: log2 of FFT points; number of stages; 1..31.
- `DRAIN_CYCLES`, default 4: idle cycles between stages for the butterfly pipeline to flush and the generator `done` to clear; legal range 2..15.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a full FFT; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; highest priority after reset.
- `busy`  out  1  high from the cycle after accepted `start` until return to IDLE.
- `fft_done`  out  1  one-cycle pulse after the last stage drains.
- `stage_count`  out  5  current stage index to generator/twiddle logic.
- `should_run`  out  1  run enable to address generator.
- `gen_done`  in  1  generator completion flag, level, registered in generator.
- `stage_start`  out  1  one-cycle pulse in the first RUN cycle of each stage.
- `bank_sel`  out  1  read bank for current stage; write bank is `~bank_sel`.
- `last_bank`  out  1  bank holding final results, captured at FINISH.

## Operation
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - `should_run`=0 and `busy`=0.
  - If `start`=1, then at the next edge: go to RUN, `stage_count`=0, `bank_sel`=0, `busy`=1.
- RUN:
  - `should_run`=1.
  - `stage_start`=1 in the first cycle only.
  - When `gen_done`=1 is sampled, go to DRAIN and load the drain counter with `DRAIN_CYCLES`-1.
- DRAIN:
  - `should_run`=0 and the counter decrements each cycle.
  - When the counter is 0:
    - If `stage_count`==`FFT_N`-1, go to FINISH.
    - Otherwise go to RUN with `stage_count`+1 and `bank_sel` toggled.
- FINISH (one cycle):
  - `fft_done`=1 and `last_bank`<=`~bank_sel`, i.e. the bank written in the last stage.
  - Go to IDLE. `busy` drops at that edge.
- `stage_count` holds its value in IDLE until the next accepted `start`. `bank_sel` likewise holds its value in IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `gen_done` outside RUN is ignored. DRAIN deliberately ignores the stale `gen_done` that persists for up to 2 cycles after `should_run` falls.
- `abort`=1 in any state: at the next edge go to IDLE with `should_run`=0 and `busy`=0. No `fft_done` pulse. `stage_count`, `bank_sel` and `last_bank` are unchanged.
- `start` and `abort` high together in IDLE: `abort` wins and the FSM stays in IDLE.
- Drain counter width is 4 bits. Stage compare uses the 5-bit `stage_count` against the constant `FFT_N`-1.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE and all outputs 0. This covers `busy`, `fft_done`, `stage_count`, `should_run`, `stage_start`, `bank_sel`, `last_bank`, and the drain counter.
- `start` sampled at edge t: RUN from t+1, where `should_run`, `busy` and `stage_start` are all 1.
- `gen_done` sampled 1 at edge t (in RUN): `should_run`=0 from t+1.
- Next stage RUN begins at t+1+`DRAIN_CYCLES`.
- `should_run` low gap between stages is exactly `DRAIN_CYCLES` cycles (at least 2 guarantees the generator counter and `done` clear).
- Per stage with K RUN cycles: K+`DRAIN_CYCLES`.
- Total cycles from `start` edge to the `fft_done` cycle: sum over stages of (K+`DRAIN_CYCLES`) + 1.
- `fft_done` high exactly one cycle; `busy` is still high during that cycle.
- A back-to-back `start` is accepted in the first IDLE cycle, i.e. the cycle after `fft_done`.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_n`=0 mid-RUN at stage 3.
  - Required: all outputs 0 immediately (asynchronous); after release the FSM stays in IDLE with `should_run`=0.
- Full run:
  - Stimulus: FFT_N=4 and DRAIN_CYCLES=4, with a stub raising `gen_done` after 8 `should_run` cycles (held until `should_run` has been low for 2 cycles).
  - Required: `stage_count` steps 0,1,2,3; `bank_sel` steps 0,1,0,1; 4 `stage_start` pulses; `fft_done` is high 49 cycles after the `start` edge; `last_bank`=0.
- Stale done:
  - Stimulus: stub holds `gen_done`=1 for 2 cycles after `should_run` falls.
  - Required: no premature stage advance; each RUN lasts the full 8 cycles.
- Abort:
  - Stimulus: `abort` pulse during DRAIN of stage 2.
  - Required: IDLE next cycle, `busy`=0, no `fft_done`, `stage_count` stays 2; a following `start` restarts at stage 0 with `bank_sel`=0.
- Ignored start:
  - Stimulus: pulse `start` during RUN and in the FINISH cycle.
  - Required: no restart, exactly one `fft_done`. A `start` in the cycle after `fft_done` begins a new run with `stage_count`=0.
- Integration with the real FFT address generator:
  - Stimulus: FFT_N=10 and DRAIN_CYCLES=2.
  - Required: 10 stages complete, and the generator `active` signal never goes high during DRAIN.
